// File: rtl/inta_sequencer_pkg.sv
// Shared definitions for the interrupt-acknowledge sequencer: state encoding,
// the 8080 CALL opcode and the one-hot level to 3-bit id conversion.
package pic_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PULSE1 = 3'd1,
    GAP1   = 3'd2,
    PULSE2 = 3'd3,
    GAP2   = 3'd4,
    PULSE3 = 3'd5
  } inta_state_e;

  localparam logic [7:0] CALL_OPCODE = 8'hCD;
  localparam logic [2:0] SPURIOUS_ID = 3'd7;

  // An all-zero level is a spurious interrupt and reports id 7.
  function automatic logic [2:0] level_to_id(input logic [7:0] level);
    logic [2:0] id;
    id = SPURIOUS_ID;
    for (int i = 0; i < 8; i++) begin
      if (level[i]) id = 3'(i);
    end
    return id;
  endfunction

endpackage

// File: rtl/inta_sequencer_if.sv
// Bus bundle between the CPU/priority-resolver side (master) and the
// interrupt-acknowledge sequencer (slave).
interface inta_sequencer_if;
  logic        inta_n;
  logic        mode_8086;
  logic        auto_eoi;
  logic [7:0]  highest_priority_interrupt;
  logic [4:0]  vector_base;
  logic [10:0] address_base;
  logic        interval_4;
  logic        acknowledge;
  logic [7:0]  latched_level;
  logic [7:0]  end_of_interrupt;
  logic [7:0]  data_out;
  logic        data_out_enable;
  logic        freeze;

  modport master (
    output inta_n, mode_8086, auto_eoi, highest_priority_interrupt,
           vector_base, address_base, interval_4,
    input  acknowledge, latched_level, end_of_interrupt, data_out,
           data_out_enable, freeze
  );

  modport slave (
    input  inta_n, mode_8086, auto_eoi, highest_priority_interrupt,
           vector_base, address_base, interval_4,
    output acknowledge, latched_level, end_of_interrupt, data_out,
           data_out_enable, freeze
  );
endinterface

// File: rtl/inta_sequencer_sync.sv
// Two-flop synchronizer for the asynchronous INTA strobe with edge detection
// on the synchronized value.
module inta_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic inta_n_i,
  output logic fall_o,
  output logic rise_o
);

  logic       sync1_q;
  logic       sync2_q;
  logic       prev_q;
  logic       armed_q;
  logic [1:0] settle_q;

  // Edges are only reported once a genuine high has passed through the chain,
  // so a pin already low at reset release never looks like a new INTA.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      prev_q   <= 1'b1;
      settle_q <= 2'b00;
      armed_q  <= 1'b0;
    end else begin
      sync1_q  <= inta_n_i;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      settle_q <= {settle_q[0], 1'b1};
      if (settle_q[1] && sync2_q) armed_q <= 1'b1;
    end
  end

  assign fall_o = armed_q & prev_q & ~sync2_q;
  assign rise_o = armed_q & ~prev_q & sync2_q;

endmodule

// File: rtl/inta_sequencer.sv
// Interrupt-acknowledge sequencer: walks the 8086 two-pulse or 8080 three-pulse
// INTA sequence, drives the vector / CALL bytes and issues ack and AEOI pulses.
module inta_sequencer
  import pic_pkg::*;
(
  input logic             clk,
  input logic             rst_n,
  inta_sequencer_if.slave bus
);

  inta_state_e state_q, state_d;
  logic        mode_q, mode_d;
  logic        aeoi_q, aeoi_d;
  logic [7:0]  level_q, level_d;
  logic        ack_q, ack_d;
  logic [7:0]  eoi_q, eoi_d;
  logic        fall;
  logic        rise;
  logic [2:0]  id;
  logic [7:0]  low_byte;
  logic [7:0]  byte_out;
  logic        drive;

  inta_sync u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .inta_n_i (bus.inta_n),
    .fall_o   (fall),
    .rise_o   (rise)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      aeoi_q  <= 1'b0;
      level_q <= 8'h00;
      ack_q   <= 1'b0;
      eoi_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      aeoi_q  <= aeoi_d;
      level_q <= level_d;
      ack_q   <= ack_d;
      eoi_q   <= eoi_d;
    end
  end

  assign id       = level_to_id(level_q);
  assign low_byte = bus.interval_4 ? {bus.address_base[2:0], id, 2'b00}
                                   : {bus.address_base[2:1], id, 3'b000};

  // Mode, AEOI and level are captured only on the opening fall and held until IDLE.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    aeoi_d   = aeoi_q;
    level_d  = level_q;
    ack_d    = 1'b0;
    eoi_d    = 8'h00;
    drive    = 1'b0;
    byte_out = 8'h00;
    case (state_q)
      IDLE: begin
        if (fall) begin
          mode_d  = bus.mode_8086;
          aeoi_d  = bus.auto_eoi;
          level_d = bus.highest_priority_interrupt;
          ack_d   = |bus.highest_priority_interrupt;
          state_d = PULSE1;
        end
      end
      PULSE1: begin
        if (!mode_q) begin
          drive    = 1'b1;
          byte_out = CALL_OPCODE;
        end
        if (rise) state_d = GAP1;
      end
      GAP1: begin
        if (fall) state_d = PULSE2;
      end
      PULSE2: begin
        drive    = 1'b1;
        byte_out = mode_q ? {bus.vector_base, id} : low_byte;
        if (rise) begin
          if (mode_q) begin
            state_d = IDLE;
            eoi_d   = aeoi_q ? level_q : 8'h00;
          end else begin
            state_d = GAP2;
          end
        end
      end
      GAP2: begin
        if (fall) state_d = PULSE3;
      end
      PULSE3: begin
        drive    = 1'b1;
        byte_out = bus.address_base[10:3];
        if (rise) begin
          state_d = IDLE;
          eoi_d   = aeoi_q ? level_q : 8'h00;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.acknowledge      = ack_q;
  assign bus.latched_level    = level_q;
  assign bus.end_of_interrupt = eoi_q;
  assign bus.data_out         = byte_out;
  assign bus.data_out_enable  = drive;
  assign bus.freeze           = (state_q != IDLE);

endmodule
